// File: rtl/store_buffer_bytemask_pkg.sv
// Store buffer shared types: configuration, entry layout, pointers
// and the age-ordered youngest-match helper used by forwarding.
package store_buffer_pkg;

  localparam int SB_DEPTH      = 8;
  localparam int SB_ADDR_WIDTH = 32;
  localparam int SB_DATA_WIDTH = 32;

  localparam int SB_STRB_WIDTH = SB_DATA_WIDTH / 8;
  localparam int SB_OFFS       = $clog2(SB_STRB_WIDTH);
  localparam int SB_IDX_W      = $clog2(SB_DEPTH);
  localparam int SB_PTR_W      = SB_IDX_W + 1;
  localparam int SB_WORD_W     = SB_ADDR_WIDTH - SB_OFFS;

  typedef logic [SB_PTR_W-1:0] sb_ptr_t;
  typedef logic [SB_IDX_W-1:0] sb_idx_t;

  typedef struct packed {
    logic [SB_WORD_W-1:0]     word;
    logic [SB_DATA_WIDTH-1:0] data;
    logic [SB_STRB_WIDTH-1:0] strobe;
  } sb_entry_t;

  // Scan backwards from the slot just below tail, so the first
  // hit is the youngest entry.
  function automatic sb_idx_t youngest_match(
    input  logic [SB_DEPTH-1:0] match,
    input  sb_idx_t             tail_idx,
    output logic                found
  );
    sb_idx_t j;
    youngest_match = '0;
    found = 1'b0;
    for (int k = 1; k <= SB_DEPTH; k++) begin
      j = tail_idx - sb_idx_t'(k);
      if (!found && match[j]) begin
        youngest_match = j;
        found = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/store_buffer_bytemask_forward.sv
// Per-byte load forwarding: picks the youngest live entry whose word
// matches and whose strobe covers the byte. Ports: entries, valid, tail_idx,
// fwd_address/fwd_strobe in; fwd_data, hit, stall out.
module sb_forward_unit
  import store_buffer_pkg::*;
(
  input  sb_entry_t                entries [SB_DEPTH],
  input  logic [SB_DEPTH-1:0]      valid,
  input  sb_idx_t                  tail_idx,
  input  logic [SB_ADDR_WIDTH-1:0] fwd_address,
  input  logic [SB_STRB_WIDTH-1:0] fwd_strobe,
  output logic [SB_DATA_WIDTH-1:0] fwd_data,
  output logic                     hit,
  output logic                     stall
);

  logic [SB_WORD_W-1:0]     word;
  logic [SB_DEPTH-1:0]      addr_match;
  logic [SB_STRB_WIDTH-1:0] covered;
  logic                     unused_offs;

  assign word = fwd_address[SB_ADDR_WIDTH-1:SB_OFFS];
  assign unused_offs = ^fwd_address[SB_OFFS-1:0];

  always_comb begin
    addr_match = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      addr_match[i] = valid[i] && (entries[i].word == word);
    end
  end

  always_comb begin
    logic [SB_DEPTH-1:0] m;
    sb_idx_t             sel;
    logic                found;
    fwd_data = '0;
    covered  = '0;
    m        = '0;
    sel      = '0;
    found    = 1'b0;
    for (int b = 0; b < SB_STRB_WIDTH; b++) begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        m[i] = addr_match[i] & entries[i].strobe[b];
      end
      sel = youngest_match(m, tail_idx, found);
      if (found && fwd_strobe[b]) begin
        covered[b] = 1'b1;
        fwd_data[b*8 +: 8] = entries[sel].data[b*8 +: 8];
      end
    end
  end

  assign hit   = (fwd_strobe != '0) && ((fwd_strobe & ~covered) == '0);
  assign stall = (covered != '0) && !hit;

endmodule

// File: rtl/store_buffer_bytemask.sv
// Byte-masked store buffer: speculative push, in-order commit, req/ack drain,
// youngest-first per-byte forwarding. Sizes come from store_buffer_pkg.
module store_buffer_bytemask
  import store_buffer_pkg::*;
#(
  localparam int DEPTH      = SB_DEPTH,
  localparam int ADDR_WIDTH = SB_ADDR_WIDTH,
  localparam int DATA_WIDTH = SB_DATA_WIDTH,
  localparam int STRB_WIDTH = DATA_WIDTH / 8,
  localparam int CNT_W      = $clog2(DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  push_valid_i,
  output logic                  push_ready_o,
  input  logic [ADDR_WIDTH-1:0] push_address_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic [STRB_WIDTH-1:0] push_strobe_i,
  input  logic                  commit_i,
  input  logic [ADDR_WIDTH-1:0] fwd_address_i,
  input  logic [STRB_WIDTH-1:0] fwd_strobe_i,
  output logic [DATA_WIDTH-1:0] fwd_data_o,
  output logic                  fwd_hit_o,
  output logic                  fwd_stall_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic [STRB_WIDTH-1:0] mem_strobe_o,
  input  logic                  mem_ack_i,
  output logic                  empty_o,
  output logic                  full_o,
  output logic                  idle_o,
  output logic [CNT_W-1:0]      count_o
);

  localparam sb_ptr_t WRAP = sb_ptr_t'(SB_DEPTH);

  sb_entry_t           mem [SB_DEPTH];
  sb_entry_t           head_e;
  sb_ptr_t             head;
  sb_ptr_t             cmt;
  sb_ptr_t             tail;
  sb_ptr_t             cmt_nxt;
  sb_ptr_t             count;
  logic [SB_DEPTH-1:0] valid;
  logic                push_acc;
  logic                commit_ok;
  logic                pop;
  logic                unused_offs;

  assign unused_offs = ^push_address_i[SB_OFFS-1:0];

  assign count        = tail - head;
  assign count_o      = count;
  assign empty_o      = head == tail;
  assign full_o       = (head ^ tail) == WRAP;
  assign idle_o       = head == cmt;
  assign push_ready_o = !full_o;
  assign mem_req_o    = head != cmt;

  // Flush drops this cycle's push; commit beyond tail is ignored.
  assign push_acc  = push_valid_i & ~full_o & ~flush_i;
  assign commit_ok = commit_i & (cmt != tail);
  assign pop       = mem_req_o & mem_ack_i;
  assign cmt_nxt   = cmt + sb_ptr_t'(commit_ok);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      head <= '0;
      cmt  <= '0;
      tail <= '0;
    end else begin
      head <= head + sb_ptr_t'(pop);
      cmt  <= cmt_nxt;
      tail <= flush_i ? cmt_nxt : tail + sb_ptr_t'(push_acc);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[tail[SB_IDX_W-1:0]] <= '{
        word:   push_address_i[SB_ADDR_WIDTH-1:SB_OFFS],
        data:   push_data_i,
        strobe: push_strobe_i
      };
    end
  end

  // Tail never overtakes head, so the head slot is stable while req is up.
  assign head_e        = mem[head[SB_IDX_W-1:0]];
  assign mem_address_o = {head_e.word, {SB_OFFS{1'b0}}};
  assign mem_data_o    = head_e.data;
  assign mem_strobe_o  = head_e.strobe;

  always_comb begin
    sb_idx_t rel;
    valid = '0;
    rel   = '0;
    for (int i = 0; i < SB_DEPTH; i++) begin
      rel = sb_idx_t'(i) - head[SB_IDX_W-1:0];
      valid[i] = {1'b0, rel} < count;
    end
  end

  sb_forward_unit u_fwd (
    .entries     (mem),
    .valid       (valid),
    .tail_idx    (tail[SB_IDX_W-1:0]),
    .fwd_address (fwd_address_i),
    .fwd_strobe  (fwd_strobe_i),
    .fwd_data    (fwd_data_o),
    .hit         (fwd_hit_o),
    .stall       (fwd_stall_o)
  );

endmodule

// File: tb/tb_store_buffer_bytemask.sv
// Testbench for store_buffer_bytemask: directed tables and sequences plus
// random traffic against a queue-based reference model.
module tb_store_buffer_bytemask;
  import store_buffer_pkg::*;

  localparam int D = SB_DEPTH;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, push_valid_i, commit_i, mem_ack_i;
  logic        push_ready_o, fwd_hit_o, fwd_stall_o, mem_req_o;
  logic        empty_o, full_o, idle_o;
  logic [31:0] push_address_i, push_data_i, fwd_address_i;
  logic [31:0] fwd_data_o, mem_address_o, mem_data_o;
  logic [3:0]  push_strobe_i, fwd_strobe_i, mem_strobe_o, count_o;

  always #5 clk = ~clk;

  store_buffer_bytemask dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
    .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
    .push_address_i(push_address_i), .push_data_i(push_data_i),
    .push_strobe_i(push_strobe_i), .commit_i(commit_i),
    .fwd_address_i(fwd_address_i), .fwd_strobe_i(fwd_strobe_i),
    .fwd_data_o(fwd_data_o), .fwd_hit_o(fwd_hit_o),
    .fwd_stall_o(fwd_stall_o), .mem_req_o(mem_req_o),
    .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
    .mem_strobe_o(mem_strobe_o), .mem_ack_i(mem_ack_i),
    .empty_o(empty_o), .full_o(full_o), .idle_o(idle_o),
    .count_o(count_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
  } ent_t;

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  strb;
    logic [31:0] data;
    logic        hit;
    logic        stall;
  } fvec_t;

  ent_t  q[$];
  int    ncom;
  int    tests = 0;
  int    fails = 0;
  fvec_t tbl[10];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void model_fwd(
    input  logic [31:0] fa,
    input  logic [3:0]  fs,
    output logic [31:0] d,
    output logic        h,
    output logic        s
  );
    logic [3:0] cov;
    logic       got;
    cov = 4'h0;
    d   = 32'h0;
    for (int b = 0; b < 4; b++) begin
      got = 1'b0;
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (!got && fs[b] && q[i].strb[b]
            && q[i].addr[31:2] == fa[31:2]) begin
          d[b*8 +: 8] = q[i].data[b*8 +: 8];
          cov[b] = 1'b1;
          got = 1'b1;
        end
      end
    end
    h = (fs != 4'h0) && ((fs & ~cov) == 4'h0);
    s = (cov != 4'h0) && !h;
  endfunction

  task automatic check_model();
    logic [31:0] d;
    logic        h, s;
    chk("m_ready", 32'(push_ready_o), 32'(q.size() < D));
    chk("m_empty", 32'(empty_o), 32'(q.size() == 0));
    chk("m_full", 32'(full_o), 32'(q.size() == D));
    chk("m_idle", 32'(idle_o), 32'(ncom == 0));
    chk("m_count", 32'(count_o), 32'(q.size()));
    chk("m_req", 32'(mem_req_o), 32'(ncom > 0));
    if (ncom > 0) begin
      chk("m_maddr", mem_address_o, {q[0].addr[31:2], 2'b00});
      chk("m_mdata", mem_data_o, q[0].data);
      chk("m_mstrb", 32'(mem_strobe_o), 32'(q[0].strb));
    end
    model_fwd(fwd_address_i, fwd_strobe_i, d, h, s);
    chk("m_fdata", fwd_data_o, d);
    chk("m_fhit", 32'(fwd_hit_o), 32'(h));
    chk("m_fstall", 32'(fwd_stall_o), 32'(s));
  endtask

  task automatic update_model();
    logic full, pacc, cok, pop;
    if (rst_i) begin
      q.delete();
      ncom = 0;
      return;
    end
    full = q.size() == D;
    pacc = push_valid_i && !full && !flush_i;
    cok  = commit_i && ncom < q.size();
    pop  = ncom > 0 && mem_ack_i;
    if (pop) begin
      void'(q.pop_front());
      ncom--;
    end
    if (cok) ncom++;
    if (flush_i) begin
      while (q.size() > ncom) void'(q.pop_back());
    end else if (pacc) begin
      q.push_back('{push_address_i, push_data_i, push_strobe_i});
    end
  endtask

  task automatic tick();
    #1;
    if (!rst_i) begin
      check_model();
      if (commit_i) chk("commit_legal", 32'(ncom < q.size()), 32'd1);
    end
    update_model();
    @(posedge clk);
    #1;
    push_valid_i = 1'b0;
    commit_i     = 1'b0;
    flush_i      = 1'b0;
    mem_ack_i    = 1'b0;
    rst_i        = 1'b0;
    #1;
  endtask

  task automatic push(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    push_valid_i   = 1'b1;
    push_address_i = a;
    push_data_i    = d;
    push_strobe_i  = s;
  endtask

  task automatic fwd(logic [31:0] a, logic [3:0] s);
    fwd_address_i = a;
    fwd_strobe_i  = s;
    #1;
  endtask

  initial begin
    tbl[0] = '{32'h200, 4'h3, 32'h0000_3322, 1'b1, 1'b0};
    tbl[1] = '{32'h200, 4'h2, 32'h0000_3300, 1'b1, 1'b0};
    tbl[2] = '{32'h200, 4'h1, 32'h0000_0022, 1'b1, 1'b0};
    tbl[3] = '{32'h200, 4'hF, 32'h0000_3322, 1'b0, 1'b1};
    tbl[4] = '{32'h300, 4'h1, 32'h0000_00EE, 1'b1, 1'b0};
    tbl[5] = '{32'h300, 4'hF, 32'h0000_00EE, 1'b0, 1'b1};
    tbl[6] = '{32'h304, 4'hF, 32'h0000_0000, 1'b0, 1'b0};
    tbl[7] = '{32'h202, 4'h3, 32'h0000_3322, 1'b1, 1'b0};
    tbl[8] = '{32'h200, 4'h0, 32'h0000_0000, 1'b0, 1'b0};
    tbl[9] = '{32'h200, 4'hC, 32'h0000_0000, 1'b0, 1'b0};

    ncom = 0;
    rst_i = 1'b1; flush_i = 1'b0; push_valid_i = 1'b0;
    commit_i = 1'b0; mem_ack_i = 1'b0;
    push_address_i = '0; push_data_i = '0; push_strobe_i = '0;
    fwd_address_i = '0; fwd_strobe_i = 4'hF;
    repeat (2) @(posedge clk);
    #1; rst_i = 1'b0; #1;

    chk("rst_ready", 32'(push_ready_o), 32'd1);
    chk("rst_empty", 32'(empty_o), 32'd1);
    chk("rst_full", 32'(full_o), 32'd0);
    chk("rst_idle", 32'(idle_o), 32'd1);
    chk("rst_count", 32'(count_o), 32'd0);
    chk("rst_req", 32'(mem_req_o), 32'd0);
    chk("rst_hit", 32'(fwd_hit_o), 32'd0);
    chk("rst_stall", 32'(fwd_stall_o), 32'd0);

    // Drain with memory wait states.
    push(32'h100, 32'hAABB_CCDD, 4'hF); tick();
    commit_i = 1'b1; tick();
    for (int i = 0; i < 3; i++) begin
      chk("wait_req", 32'(mem_req_o), 32'd1);
      chk("wait_addr", mem_address_o, 32'h100);
      chk("wait_data", mem_data_o, 32'hAABB_CCDD);
      chk("wait_strb", 32'(mem_strobe_o), 32'hF);
      tick();
    end
    mem_ack_i = 1'b1; tick();
    chk("drain_empty", 32'(empty_o), 32'd1);
    chk("drain_idle", 32'(idle_o), 32'd1);

    // Forwarding table.
    push(32'h200, 32'hDEAD_1122, 4'h3); tick();
    push(32'h200, 32'hBEEF_33FF, 4'h2); tick();
    push(32'h300, 32'h1234_56EE, 4'h1); tick();
    foreach (tbl[i]) begin
      fwd(tbl[i].addr, tbl[i].strb);
      chk($sformatf("fwd%0d_data", i), fwd_data_o, tbl[i].data);
      chk($sformatf("fwd%0d_hit", i), 32'(fwd_hit_o), 32'(tbl[i].hit));
      chk($sformatf("fwd%0d_stall", i), 32'(fwd_stall_o), 32'(tbl[i].stall));
    end
    flush_i = 1'b1; tick();
    chk("flush_all_empty", 32'(empty_o), 32'd1);

    // Flush keeps committed entries and drops a same-cycle push.
    for (int i = 0; i < 4; i++) begin
      push(32'h400 + 32'(4 * i), 32'h1000 + 32'(i), 4'hF); tick();
    end
    commit_i = 1'b1; tick();
    commit_i = 1'b1; tick();
    flush_i = 1'b1;
    push(32'h410, 32'hEEEE_EEEE, 4'hF); tick();
    chk("flush_count", 32'(count_o), 32'd2);
    chk("flush_idle", 32'(idle_o), 32'd0);
    fwd(32'h410, 4'hF);
    chk("flush_gone_hit", 32'(fwd_hit_o), 32'd0);
    chk("flush_gone_stall", 32'(fwd_stall_o), 32'd0);
    chk("flush_ord0", mem_address_o, 32'h400);
    mem_ack_i = 1'b1; tick();
    chk("flush_ord1", mem_address_o, 32'h404);
    mem_ack_i = 1'b1; tick();
    chk("flush_done", 32'(empty_o), 32'd1);

    // Full buffer ignores a push even when a pop happens that cycle.
    for (int i = 0; i < D; i++) begin
      push(32'h500 + 32'(4 * i), 32'(i), 4'hF); tick();
    end
    chk("fill_full", 32'(full_o), 32'd1);
    chk("fill_ready", 32'(push_ready_o), 32'd0);
    chk("fill_count", 32'(count_o), 32'(D));
    commit_i = 1'b1; tick();
    push(32'h600, 32'h6666_6666, 4'hF);
    mem_ack_i = 1'b1; tick();
    chk("full_pop_count", 32'(count_o), 32'(D - 1));
    chk("full_pop_full", 32'(full_o), 32'd0);
    fwd(32'h600, 4'hF);
    chk("full_push_gone", 32'(fwd_hit_o), 32'd0);
    flush_i = 1'b1; tick();

    // Push, commit and pop together, then reset mid-request.
    push(32'h700, 32'h70, 4'hF); tick();
    push(32'h704, 32'h74, 4'hF); tick();
    push(32'h708, 32'h78, 4'hF); tick();
    commit_i = 1'b1; tick();
    push(32'h70C, 32'h7C, 4'hF);
    commit_i = 1'b1; mem_ack_i = 1'b1; tick();
    chk("tri_count", 32'(count_o), 32'd3);
    chk("tri_head", mem_address_o, 32'h704);
    chk("tri_req", 32'(mem_req_o), 32'd1);
    rst_i = 1'b1; tick();
    chk("rst_mid_req", 32'(mem_req_o), 32'd0);
    chk("rst_mid_empty", 32'(empty_o), 32'd1);

    // Random traffic against the model.
    for (int n = 0; n < 4000; n++) begin
      push_valid_i   = 1'($urandom_range(0, 1));
      push_address_i = 32'h100 + 32'($urandom_range(0, 15));
      push_data_i    = $urandom;
      push_strobe_i  = 4'($urandom_range(0, 15));
      commit_i       = ($urandom_range(0, 1) == 1) && (ncom < q.size());
      flush_i        = $urandom_range(0, 31) == 0;
      mem_ack_i      = 1'($urandom_range(0, 1));
      fwd_address_i  = 32'h100 + 32'($urandom_range(0, 19));
      fwd_strobe_i   = 4'($urandom_range(0, 15));
      rst_i          = $urandom_range(0, 499) == 0;
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
